// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle scheduler: FSM states, obstacle
// heights, colours and the LFSR-to-height mapping.
package obstacle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ERASE,
        MOVE,
        DRAW
    } state_t;

    localparam logic [6:0] H_SMALL      = 7'd30;
    localparam logic [6:0] H_MED        = 7'd60;
    localparam logic [6:0] H_LARGE      = 7'd90;
    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [3:0] LFSR_SEED    = 4'b1110;

    // Roughly 6/16 small, 5/16 medium, 5/16 large.
    function automatic logic [6:0] height_map(input logic [3:0] r);
        if (r < 4'd6) begin
            return H_SMALL;
        end else if (r < 4'd11) begin
            return H_MED;
        end
        return H_LARGE;
    endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// Free-running 4-bit LFSR supplying the pseudo-random height on each wrap.
module obstacle_lfsr
    import obstacle_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] value
);

    logic [3:0] lfsr_q;
    logic [3:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[2], lfsr_q[1], lfsr_q[0], lfsr_q[2] ^ lfsr_q[3]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Per-frame erase / move / redraw sequencer for one obstacle rectangle,
// emitting one framebuffer pixel write per clock.
module obstacle_scheduler
    import obstacle_pkg::*;
#(
    parameter int          OBS_W      = 11,
    parameter int          SCREEN_W   = 160,
    parameter int          GROUND_Y   = 120,
    parameter logic [2:0]  OBS_COLOUR = 3'b010
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       go,
    input  logic [2:0] speed,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic [7:0] obs_x,
    output logic [6:0] obs_h,
    output logic       wrapped
);

    localparam logic [7:0] WRAP_X  = 8'(SCREEN_W - OBS_W);
    localparam logic [3:0] CX_LAST = 4'(OBS_W - 1);
    localparam logic [6:0] GROUND  = 7'(GROUND_Y);

    state_t     state_q, state_d;
    logic [3:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
    logic [7:0] x0_q, x0_d;
    logic [6:0] h_q, h_d;
    logic       drawn_q, drawn_d;
    logic       pending_q, pending_d;
    logic [7:0] x_out_q, x_out_d;
    logic [6:0] y_out_q, y_out_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;

    logic [3:0] lfsr_value;
    logic [7:0] step;
    logic       scan_last;
    logic       wrap_now;

    obstacle_lfsr u_lfsr (
        .clock (clock),
        .reset (reset),
        .value (lfsr_value)
    );

    assign step      = (speed == 3'd0) ? 8'd1 : {5'd0, speed};
    assign scan_last = (cx_q == CX_LAST) && (cy_q == h_q - 7'd1);
    assign wrap_now  = drawn_q && (x0_q < step);

    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        x0_d      = x0_q;
        h_d       = h_q;
        drawn_d   = drawn_q;
        pending_d = pending_q;

        if ((state_q != IDLE) && frame_tick && go) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!go) begin
                    pending_d = 1'b0;
                end else if (frame_tick || pending_q) begin
                    state_d   = drawn_q ? ERASE : MOVE;
                    pending_d = 1'b0;
                    cx_d      = 4'd0;
                    cy_d      = 7'd0;
                end
            end
            ERASE, DRAW: begin
                if (cx_q == CX_LAST) begin
                    cx_d = 4'd0;
                    cy_d = cy_q + 7'd1;
                end else begin
                    cx_d = cx_q + 4'd1;
                end
                if (scan_last) begin
                    cy_d = 7'd0;
                    if (state_q == ERASE) begin
                        state_d = MOVE;
                    end else begin
                        state_d = IDLE;
                        drawn_d = 1'b1;
                    end
                end
            end
            MOVE: begin
                state_d = DRAW;
                cx_d    = 4'd0;
                cy_d    = 7'd0;
                if (wrap_now) begin
                    x0_d = WRAP_X;
                    h_d  = height_map(lfsr_value);
                end else if (drawn_q) begin
                    x0_d = x0_q - step;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pixel outputs are built from next-cycle values so they line up with the state they belong to.
        plot_d   = (state_d == ERASE) || (state_d == DRAW);
        x_out_d  = x_out_q;
        y_out_d  = y_out_q;
        colour_d = colour_q;
        if (plot_d) begin
            x_out_d  = x0_d + {4'd0, cx_d};
            y_out_d  = GROUND - h_d + cy_d;
            colour_d = (state_d == DRAW) ? OBS_COLOUR : COLOUR_BLACK;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cx_q      <= 4'd0;
            cy_q      <= 7'd0;
            x0_q      <= WRAP_X;
            h_q       <= H_LARGE;
            drawn_q   <= 1'b0;
            pending_q <= 1'b0;
            x_out_q   <= 8'd0;
            y_out_q   <= 7'd0;
            colour_q  <= COLOUR_BLACK;
            plot_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            x0_q      <= x0_d;
            h_q       <= h_d;
            drawn_q   <= drawn_d;
            pending_q <= pending_d;
            x_out_q   <= x_out_d;
            y_out_q   <= y_out_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
        end
    end

    assign x_out   = x_out_q;
    assign y_out   = y_out_q;
    assign colour  = colour_q;
    assign plot    = plot_q;
    assign busy    = (state_q != IDLE);
    assign obs_x   = x0_q;
    assign obs_h   = h_q;
    assign wrapped = (state_q == MOVE) && wrap_now;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: frame sequences tracked against a
// small position/height model, with pixel-by-pixel scan order checks.
module tb_obstacle_scheduler;

    logic       clock;
    logic       reset;
    logic       frame_tick;
    logic       go;
    logic [2:0] speed;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic [7:0] obs_x;
    logic [6:0] obs_h;
    logic       wrapped;

    int n_cmp = 0;
    int n_err = 0;

    int         mx0;
    int         mh;
    logic       mdrawn;
    logic [3:0] ml;

    obstacle_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .go         (go),
        .speed      (speed),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .obs_x      (obs_x),
        .obs_h      (obs_h),
        .wrapped    (wrapped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference LFSR: q0 <= q2^q3, q1 <= q0, q2 <= q1, q3 <= q2; seed 1110.
    always @(posedge clock) begin
        if (reset) ml <= 4'b1110;
        else       ml <= {ml[2], ml[1], ml[0], ml[2] ^ ml[3]};
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int exp_height(input logic [3:0] r);
        if (r < 4'd6)  return 30;
        if (r < 4'd11) return 60;
        return 90;
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Called on a negedge while IDLE; returns on the negedge of the first sequence cycle.
    task automatic start_frame(input int spd);
        speed      = 3'(spd);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    // Follows one sequence from its first cycle to the IDLE cycle after it.
    task automatic run_seq(input string tag, input int spd, input bit extra_ticks);
        int   s, ox, oh, nx, nh, exp_w;
        int   e_cnt, d_cnt, mv_cnt, w_cnt, busy_cnt, bad, cyc;
        logic was_drawn;
        s = (spd == 0) ? 1 : spd;
        ox = mx0; oh = mh; was_drawn = mdrawn;
        nx = ox;  nh = oh; exp_w = 0;
        if (mdrawn) begin
            if (ox < s) begin
                nx = 149;
                exp_w = 1;
            end else begin
                nx = ox - s;
            end
        end
        e_cnt = 0; d_cnt = 0; mv_cnt = 0; w_cnt = 0; busy_cnt = 0; bad = 0; cyc = 0;
        while (busy && cyc < 5000) begin
            busy_cnt++;
            if (wrapped) w_cnt++;
            if (plot) begin
                if (mv_cnt == 0) begin
                    if (colour !== 3'b000 || x_out !== 8'(ox + e_cnt % 11) ||
                        y_out !== 7'(120 - oh + e_cnt / 11)) bad++;
                    e_cnt++;
                end else begin
                    if (colour !== 3'b010 || x_out !== 8'(nx + d_cnt % 11) ||
                        y_out !== 7'(120 - nh + d_cnt / 11)) bad++;
                    d_cnt++;
                end
            end else begin
                mv_cnt++;
                if (exp_w != 0) nh = exp_height(ml);
                if (wrapped !== 1'(exp_w)) bad++;
            end
            frame_tick = extra_ticks && (mv_cnt > 0) &&
                         (d_cnt == 5 || d_cnt == 50 || d_cnt == 100);
            @(negedge clock);
            cyc++;
        end
        frame_tick = 1'b0;
        check_eq({tag, "_done"}, busy, 0);
        check_eq({tag, "_busy_len"}, busy_cnt, (was_drawn ? 11 * oh : 0) + 1 + 11 * nh);
        check_eq({tag, "_erase_px"}, e_cnt, was_drawn ? 11 * oh : 0);
        check_eq({tag, "_draw_px"}, d_cnt, 11 * nh);
        check_eq({tag, "_move_cyc"}, mv_cnt, 1);
        check_eq({tag, "_wrapped"}, w_cnt, exp_w);
        check_eq({tag, "_bad_px"}, bad, 0);
        check_eq({tag, "_obs_x"}, obs_x, nx);
        check_eq({tag, "_obs_h"}, obs_h, nh);
        mx0 = nx; mh = nh; mdrawn = 1'b1;
    endtask

    initial begin
        int cnt, cyc, busy_seen, plot_seen;
        reset = 1'b1; frame_tick = 1'b0; go = 1'b0; speed = 3'd1;
        mx0 = 149; mh = 90; mdrawn = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_eq("rst_plot", plot, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_wrapped", wrapped, 0);
        check_eq("rst_x_out", x_out, 0);
        check_eq("rst_y_out", y_out, 0);
        check_eq("rst_colour", colour, 0);
        check_eq("rst_obs_x", obs_x, 149);
        check_eq("rst_obs_h", obs_h, 90);
        go = 1'b1;
        @(negedge clock);

        // First frame after reset: draw only.
        start_frame(1);
        run_seq("first", 1, 1'b0);

        // Reset on the 500th erase cycle, then a draw-only frame again.
        start_frame(3);
        cnt = 0; cyc = 0;
        while (cnt < 500 && cyc < 5000) begin
            if (plot && colour == 3'b000) cnt++;
            if (cnt < 500) begin
                @(negedge clock);
                cyc++;
            end
        end
        check_eq("mid_erase_reached", cnt, 500);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("mrst_plot", plot, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_x_out", x_out, 0);
        check_eq("mrst_y_out", y_out, 0);
        check_eq("mrst_colour", colour, 0);
        check_eq("mrst_obs_x", obs_x, 149);
        check_eq("mrst_obs_h", obs_h, 90);
        mx0 = 149; mh = 90; mdrawn = 1'b0;
        start_frame(1);
        run_seq("after_rst", 1, 1'b0);

        start_frame(3);
        run_seq("spd3", 3, 1'b0);
        start_frame(0);
        run_seq("spd0_a", 0, 1'b0);
        start_frame(0);
        run_seq("spd0_b", 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            start_frame(7);
            run_seq("spd7", 7, 1'b0);
        end
        start_frame(2);
        run_seq("to_x2", 2, 1'b0);
        check_eq("at_x2", obs_x, 2);

        // Wrap from x0=2 at speed 3.
        start_frame(3);
        run_seq("wrap", 3, 1'b0);
        check_eq("wrap_h_legal", int'(obs_h == 7'd30 || obs_h == 7'd60 || obs_h == 7'd90), 1);

        // Three ticks during DRAW give exactly one extra sequence.
        start_frame(1);
        run_seq("pend_a", 1, 1'b1);
        @(negedge clock);
        check_eq("pend_start_busy", busy, 1);
        check_eq("pend_start_plot", plot, 1);
        run_seq("pend_b", 1, 1'b0);
        busy_seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (busy) busy_seen++;
        end
        check_eq("pend_no_third", busy_seen, 0);

        // go low: ticks ignored.
        go = 1'b0;
        start_frame(1);
        busy_seen = 0; plot_seen = 0;
        repeat (30) begin
            if (busy) busy_seen++;
            if (plot) plot_seen++;
            @(negedge clock);
        end
        check_eq("go0_busy", busy_seen, 0);
        check_eq("go0_plot", plot_seen, 0);
        go = 1'b1;
        busy_seen = 0;
        repeat (5) begin
            @(negedge clock);
            if (busy) busy_seen++;
        end
        check_eq("go0_no_pending", busy_seen, 0);
        check_eq("go0_obs_x", obs_x, mx0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
